// File: rtl/ram_dp_sync_if.sv
// Purpose : request/response bundle between a RAM user (master) and ram_dp_sync (slave).
// Latency : none (wires only); read data arrives one cycle after a sampled read request.
// Backpressure: none in the bundle; busy tells the master that requests are being dropped.
//
// Ports (signals):
//   add_r/r_en          read address and read request         (master -> slave)
//   data_r/r_valid      registered read data and valid strobe (slave -> master)
//   add_w/data_w/w_en   write address, data and request      (master -> slave)
//   w_be                per-lane write enables                (master -> slave)
//   busy                zero-fill in progress                 (slave -> master)
interface ram_dp_sync_if #(
  parameter int AddressSize = 10,
  parameter int WordSize    = 8,
  parameter int LaneSize    = 8
);
  localparam int Lanes = WordSize / LaneSize;

  logic [AddressSize-1:0] add_r;
  logic                   r_en;
  logic [WordSize-1:0]    data_r;
  logic                   r_valid;
  logic [AddressSize-1:0] add_w;
  logic [WordSize-1:0]    data_w;
  logic                   w_en;
  logic [Lanes-1:0]       w_be;
  logic                   busy;

  modport master (
    output add_r, r_en, add_w, data_w, w_en, w_be,
    input  data_r, r_valid, busy
  );

  modport slave (
    input  add_r, r_en, add_w, data_w, w_en, w_be,
    output data_r, r_valid, busy
  );
endinterface

// File: rtl/ram_dp_sync.sv
// Purpose : simple dual-port RAM (1 write, 1 read, one clock) with lane enables and optional zero-fill.
// Latency : read data and r_valid one cycle after the edge that samples r_en; writes land at the edge.
// Backpressure: none per request; while busy (zero-fill running) all requests are silently dropped.
//
// Ports:
//   clk   clock, everything happens on the rising edge
//   rst   synchronous active-high reset; restarts the zero-fill when ClearOnReset=1
//   bus   ram_dp_sync_if.slave: add_r/r_en -> data_r/r_valid, add_w/data_w/w_en/w_be, busy
module ram_dp_sync #(
  parameter int AddressSize  = 10,
  parameter int WordSize     = 8,
  parameter int LaneSize     = 8,
  parameter int ReadMode     = 0,  // 0: collision returns old word, 1: returns merged new word
  parameter int ClearOnReset = 1   // 1: zero every word after reset
) (
  input  logic          clk,
  input  logic          rst,
  ram_dp_sync_if.slave  bus
);

  localparam int Lanes = WordSize / LaneSize;
  localparam int Depth = 1 << AddressSize;
  localparam logic [AddressSize-1:0] LastAddr = {AddressSize{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [AddressSize-1:0] cnt_q, cnt_d;

  logic [WordSize-1:0]    mem_q [Depth];
  logic [WordSize-1:0]    data_r_q;
  logic                   r_valid_q;

  logic                   busy_o;
  logic                   clr_we;
  logic                   rd_fire;
  logic                   wr_fire;
  logic [WordSize-1:0]    rd_word;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (ClearOnReset != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The fill walks every address once; leaving CLEAR happens
  // on the same edge that zeroes the last word.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + AddressSize'(1);
        if (cnt_q == LastAddr) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Requests are only honoured in READY.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o  = 1'b0;
    clr_we  = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy_o = 1'b1;
        clr_we = 1'b1;
      end
      ST_READY: begin
        rd_fire = bus.r_en;
        wr_fire = bus.w_en;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read word selection. In write-first mode a same-address write is bypassed
  // lane by lane so the read sees exactly what the memory will hold afterwards.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = mem_q[bus.add_r];
    if ((ReadMode != 0) && wr_fire && (bus.add_r == bus.add_w)) begin
      for (int i = 0; i < Lanes; i++) begin
        if (bus.w_be[i]) begin
          rd_word[i*LaneSize +: LaneSize] = bus.data_w[i*LaneSize +: LaneSize];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array. No reset on the array itself; a reset edge must not write,
  // so both fill and user writes are gated by rst.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < Lanes; i++) begin
          if (bus.w_be[i]) begin
            mem_q[bus.add_w][i*LaneSize +: LaneSize] <= bus.data_w[i*LaneSize +: LaneSize];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port. data_r holds its value when no read fires.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_fire;
      if (rd_fire) begin
        data_r_q <= rd_word;
      end
    end
  end

  assign bus.data_r  = data_r_q;
  assign bus.r_valid = r_valid_q;
  assign bus.busy    = busy_o;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: three instances share one stimulus stream
//   u0: ReadMode=0, ClearOnReset=1   u1: ReadMode=1, ClearOnReset=1   u2: ReadMode=0, ClearOnReset=0
// all with AddressSize=4, WordSize=32, LaneSize=8.
module tb_ram_dp_sync;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NL = DW / LW;
  localparam int ND = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] t_add_r = '0;
  logic          t_r_en  = 1'b0;
  logic [AW-1:0] t_add_w = '0;
  logic [DW-1:0] t_data_w = '0;
  logic          t_w_en  = 1'b0;
  logic [NL-1:0] t_w_be  = '0;

  ram_dp_sync_if #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW)) if0 ();
  ram_dp_sync_if #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW)) if1 ();
  ram_dp_sync_if #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW)) if2 ();

  assign if0.add_r = t_add_r;  assign if0.r_en = t_r_en;  assign if0.add_w = t_add_w;
  assign if0.data_w = t_data_w; assign if0.w_en = t_w_en; assign if0.w_be = t_w_be;
  assign if1.add_r = t_add_r;  assign if1.r_en = t_r_en;  assign if1.add_w = t_add_w;
  assign if1.data_w = t_data_w; assign if1.w_en = t_w_en; assign if1.w_be = t_w_be;
  assign if2.add_r = t_add_r;  assign if2.r_en = t_r_en;  assign if2.add_w = t_add_w;
  assign if2.data_w = t_data_w; assign if2.w_en = t_w_en; assign if2.w_be = t_w_be;

  ram_dp_sync #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW), .ReadMode(0), .ClearOnReset(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  ram_dp_sync #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW), .ReadMode(1), .ClearOnReset(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  ram_dp_sync #(.AddressSize(AW), .WordSize(DW), .LaneSize(LW), .ReadMode(0), .ClearOnReset(0))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  logic [DW-1:0] o_data  [3];
  logic          o_valid [3];
  logic          o_busy  [3];
  assign o_data[0] = if0.data_r; assign o_valid[0] = if0.r_valid; assign o_busy[0] = if0.busy;
  assign o_data[1] = if1.data_r; assign o_valid[1] = if1.r_valid; assign o_busy[1] = if1.busy;
  assign o_data[2] = if2.data_r; assign o_valid[2] = if2.r_valid; assign o_busy[2] = if2.busy;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one memory image and output state per instance.
  // ---------------------------------------------------------------------------
  int            m_mode  [3] = '{0, 1, 0};
  int            m_clear [3] = '{1, 1, 0};
  logic [DW-1:0] m_mem   [3][ND];
  logic [DW-1:0] m_rdata [3];
  logic          m_rvalid[3];
  int            m_left  [3];   // fill cycles still to run
  bit            started = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NL-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NL; i++)
      if (be[i]) r[i*LW +: LW] = new_w[i*LW +: LW];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        started     = 1'b1;
        m_rvalid[k] = 1'b0;
        m_rdata[k]  = '0;
        m_left[k]   = m_clear[k] ? ND : 0;
        if (m_clear[k] != 0)
          for (int a = 0; a < ND; a++) m_mem[k][a] = '0;
      end else if (m_left[k] > 0) begin
        m_left[k]   = m_left[k] - 1;
        m_rvalid[k] = 1'b0;
      end else begin
        logic [DW-1:0] merged;
        merged = merge(m_mem[k][t_add_w], t_data_w, t_w_be);
        m_rvalid[k] = t_r_en;
        if (t_r_en) begin
          if (m_mode[k] == 1 && t_w_en && t_add_r == t_add_w) m_rdata[k] = merged;
          else                                                 m_rdata[k] = m_mem[k][t_add_r];
        end
        if (t_w_en) m_mem[k][t_add_w] = merged;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), {31'b0, o_busy[k]}, {31'b0, (m_left[k] > 0)});
        chk($sformatf("r_valid[%0d]", k), {31'b0, o_valid[k]}, {31'b0, m_rvalid[k]});
        if (!$isunknown(m_rdata[k]))
          chk($sformatf("data_r[%0d]", k), o_data[k], m_rdata[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    t_r_en = 1'b0; t_w_en = 1'b0; t_w_be = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    t_w_en = 1'b1; t_add_w = a; t_data_w = d; t_w_be = be;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    t_r_en = 1'b1; t_add_r = a;
  endtask

  // Pulse reset one edge, then count edges until busy of u0 falls.
  task automatic reset_and_fill(input bit poke_busy, output int n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (if0.busy && n < 100) begin
      if (poke_busy && n == 0) begin
        wr(4'd2, 32'h000000FF, 4'b1111);
        rd(4'd2);
      end else begin
        idle();
      end
      step();
      n++;
    end
    idle();
  endtask

  initial begin
    int n;

    // Reset fill, with requests offered during the fill.
    reset_and_fill(1'b1, n);
    chk("fill_cycles", 32'(n), 32'd16);
    chk("u2_busy_after_rst", {31'b0, if2.busy}, 32'd0);

    // Every word reads zero after the fill, back-to-back.
    for (int a = 0; a < ND; a++) begin
      rd(AW'(a));
      step();
      chk($sformatf("fill_rd%0d", a), if0.data_r, 32'h0);
      chk($sformatf("fill_vld%0d", a), {31'b0, if0.r_valid}, 32'd1);
    end
    idle();

    // Basic write then read, then idle hold.
    wr(4'd3, 32'h000000A5, 4'b0001);
    step();
    idle();
    rd(4'd3);
    step();
    chk("basic_rd", if0.data_r, 32'h000000A5);
    chk("basic_vld", {31'b0, if0.r_valid}, 32'd1);
    idle();
    step();
    chk("basic_idle_vld", {31'b0, if0.r_valid}, 32'd0);
    chk("basic_idle_hold", if0.data_r, 32'h000000A5);

    // Lane enables.
    wr(4'd5, 32'h11223344, 4'b1111);
    step();
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    step();
    idle();
    rd(4'd5);
    step();
    chk("lanes_u0", if0.data_r, 32'h11BB33DD);
    chk("lanes_u1", if1.data_r, 32'h11BB33DD);

    // Different addresses in the same edge do not interact.
    wr(4'd6, 32'hDEADBEEF, 4'b1111);
    rd(4'd5);
    step();
    chk("noint_u1", if1.data_r, 32'h11BB33DD);
    idle();

    // Collision.
    wr(4'd7, 32'h11223344, 4'b1111);
    step();
    wr(4'd7, 32'hAABBCCDD, 4'b0011);
    rd(4'd7);
    step();
    chk("coll_rf_u0", if0.data_r, 32'h11223344);
    chk("coll_wf_u1", if1.data_r, 32'h1122CCDD);
    idle();
    rd(4'd7);
    step();
    chk("coll_after_u0", if0.data_r, 32'h1122CCDD);
    chk("coll_after_u1", if1.data_r, 32'h1122CCDD);
    idle();

    // Reset mid-operation, including a reset in the middle of a fill.
    wr(4'd1, 32'h0000005A, 4'b0001);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("midfill_busy", {31'b0, if0.busy}, 32'd1);
    reset_and_fill(1'b0, n);
    chk("refill_cycles", 32'(n), 32'd16);
    rd(4'd1);
    step();
    chk("refill_rd_u0", if0.data_r, 32'h0);
    chk("refill_rd_u1", if1.data_r, 32'h0);
    chk("noclear_keep_u2", if2.data_r, 32'h0000005A);
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
- Parametrised simple dual-port RAM: one write port and one read port on a single clock.
- Adds lane (byte) write enables, a registered read with a valid strobe, and a selectable read-during-write collision mode.
- Optional hardware zero-fill after reset; `busy` is asserted while the fill runs.
- Used as the general storage primitive for register files, buffers and scratch memory in the processor datapath.

Parameters:
- AddressSize, 10, address width; depth = 2^AddressSize words.
- WordSize, 8, data width in bits; must be an integer multiple of LaneSize.
- LaneSize, 8, bits per write-enable lane; Lanes = WordSize/LaneSize.
- ReadMode, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data bypassed).
- ClearOnReset, 1, 1 = zero-fill all words after reset; 0 = contents undefined and no fill.

Ports:
- clk  input  1  clock; all activity on the rising edge.
- rst  input  1  synchronous, active-high reset.
- add_r  input  AddressSize  read address.
- r_en  input  1  read request, sampled at the rising edge.
- data_r  output  WordSize  registered read data.
- r_valid  output  1  data_r holds the result of the read sampled at the previous edge.
- add_w  input  AddressSize  write address.
- data_w  input  WordSize  write data.
- w_en  input  1  write request.
- w_be  input  Lanes  per-lane write enable; bit i covers data_w[i*LaneSize +: LaneSize].
- busy  output  1  clear in progress; all requests are ignored while high.

Behaviour:
- Reset (rst high at an edge):
  - r_valid=0, data_r=0, clear counter=0.
  - State becomes CLEAR if ClearOnReset=1, otherwise READY.
  - busy=1 in CLEAR, 0 in READY.
  - Reset overrides every other input. No memory writes from w_en occur on a reset edge.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each edge writes all-zero to mem[cnt], then cnt increments.
  - After the write to address 2^AddressSize-1, the next state is READY and busy falls on that same edge. The fill therefore takes exactly 2^AddressSize cycles after reset deasserts.
  - r_en, w_en and w_be are ignored; r_valid stays 0 and data_r holds 0.
  - rst asserted mid-clear restarts the fill at address 0.
- READY, write:
  - At an edge with w_en=1, each lane i with w_be[i]=1 is updated from data_w; lanes with w_be[i]=0 keep their old value.
  - w_en=1 with w_be=0 changes nothing.
- READY, read:
  - At edge N with r_en=1: data_r = mem[add_r] and r_valid=1 after edge N. Latency is one cycle.
  - At an edge with r_en=0: r_valid=0 and data_r holds its previous value.
  - Back-to-back reads at full rate are supported.
- Collision (r_en and w_en both high at the same edge, add_r == add_w):
  - ReadMode=0: data_r returns the pre-write word.
  - ReadMode=1: data_r returns the merged word, i.e. data_w lanes where w_be=1 and old lanes elsewhere.
  - The memory is updated identically in both modes.
- Different read and write addresses at the same edge never interact.
- Addresses are full-width with no wrap logic; every address value is valid.
- ClearOnReset=0: READY is entered directly and reads of never-written words return undefined data (X in simulation).

Test Plan:
- Reset fill: ClearOnReset=1, AddressSize=4. Pulse rst one cycle -> busy high for exactly 16 cycles. Then read addresses 0..15 -> data_r=0 and r_valid=1 one cycle after each request.
- Basic access: w_en, add_w=3, data_w=0xA5, w_be=1. Next cycle r_en, add_r=3 -> data_r=0xA5 with r_valid=1 one cycle later. The following idle cycle -> r_valid=0, data_r still 0xA5.
- Lane enables: WordSize=32. Write 0x11223344 with w_be=4'b1111, then 0xAABBCCDD with w_be=4'b0101 to the same address. Read back -> 0x11BB33DD.
- Collision: address 7 holds 0x11223344. Same edge: write 0xAABBCCDD with w_be=4'b0011 and read address 7 -> ReadMode=0 gives 0x11223344, ReadMode=1 gives 0x1122CCDD. A later read gives 0x1122CCDD in both modes.
- Requests during busy: w_en to address 2 with 0xFF, and r_en, during CLEAR -> r_valid stays 0. After busy falls, reading address 2 returns 0x00.
- Reset mid-operation: write 0x5A to address 1, then assert rst midway through a subsequent fill -> fill restarts, busy lasts the full 2^AddressSize cycles from the last reset, and address 1 then reads 0x00.
